pe_out_pool_reader: RTL and testbench
=====================================

# pe_out_pool_reader

Drains the PE output FIFO on the `pe_out` side of a convolution stage and applies 2x2 / stride-2 signed max pooling. Pooled words go to the next layer's row-buffer writer. The block is the reading end of the `pe2row_*` interface: it issues `pe2row_fifo_array1_rden` against FIFO occupancy. It holds one line of horizontal maxima so each even/odd input row pair yields one pooled row.

## Interface
- `DATA_WIDTH`, 8: pixel width, signed two's complement.
- `LANES`, 8: pixels per FIFO word. Must be even.
- `WORDS`, 4: FIFO words per input row.
- `H_IN`, 32: input rows per channel. Must be even.
- `CHANNELS`, 256: channels per frame, processed channel-outer.
- `ROW_WIDTH`, 10: width of the row, column and channel index outputs.
- `clk` in 1: clock.
- `rstn` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle pulse that begins a frame. Ignored unless in IDLE.
- `pe2row_data_valid` in 1: PE output FIFO non-empty.
- `pe2row_fifo_array1_rden` out 1: FIFO read strobe.
- `fifo_array1_dataout` in LANES*DATA_WIDTH: FIFO read data, valid exactly 1 cycle after `rden`. Lane i is `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `pe2row_ready` out 1: reader active (state EVEN or ODD).
- `pool_data` out LANES/2*DATA_WIDTH: pooled word. Lane j = max of input lanes 2j and 2j+1 across both rows.
- `pool_valid` out 1: `pool_data` valid.
- `pool_ready` in 1: downstream accepts the word.
- `pool_row` out ROW_WIDTH: pooled row index, 0..H_IN/2-1.
- `pool_col` out ROW_WIDTH: word index, 0..WORDS-1.
- `pool_channel` out ROW_WIDTH: channel index.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse at frame completion.

## Operation
- **FSM states:** IDLE, EVEN, ODD, FLUSH.
  - IDLE -> EVEN on `start`.
  - EVEN -> ODD after read #WORDS of the row is issued.
  - ODD -> EVEN after the last read of the row, unless it is the last row of the last channel.
  - That final case goes ODD -> FLUSH.
  - FLUSH -> IDLE when no read is in flight and the output queue is empty. `done` pulses in that transition cycle.
- **Read counters:** `w`, `y`, `c` advance on each issued `rden`. `w` wraps at WORDS and carries to `y`; `y` wraps at H_IN and carries to `c`; `c` wraps at CHANNELS.
- **In-flight flag:** one bit. Set on `rden`, consumed the next cycle together with the counter snapshot taken at issue.
- **EVEN row return:** compute the horizontal max per lane pair and write it to `line_buf[w]`. `line_buf` has WORDS entries of LANES/2*DATA_WIDTH bits.
- **ODD row return:** horizontal max, then signed max against `line_buf[w]`. Push the result with {y/2, w, c} into a 2-entry output queue.
- **Queue head** drives `pool_data`, `pool_row`, `pool_col` and `pool_channel`. `pool_valid` = queue non-empty. The queue pops when `pool_valid && pool_ready`.
- **`rden` rules:**
  - EVEN: `rden = pe2row_data_valid`.
  - ODD: `rden = pe2row_data_valid && (queue_count - pop + inflight) < 2`.
  - Otherwise 0.
- **Max compare:** signed. Ties are irrelevant. No saturation or widening.
- **Backpressure:** no FIFO data is ever dropped. The output queue never overflows.

## Timing
- **Reset values:** `rden`=0, `pe2row_ready`=0, `pool_valid`=0, `pool_data`=0, `pool_row`/`pool_col`/`pool_channel`=0, `busy`=0, `done`=0. State = IDLE, counters = 0, queue empty, in-flight = 0. `line_buf` contents are don't-care.
- **Reset mid-frame:** immediate return to IDLE. In-flight data is discarded and the queue is cleared.
- **First read:** the first `rden` can occur in the cycle after `start` is sampled.
- **Latency:** `rden` of an odd-row word (cycle t) -> `pool_valid` at t+2 if the queue was empty.
- **Throughput:** one word per cycle when the FIFO stays non-empty and `pool_ready`=1.
- **Simultaneous push and pop:** allowed, count unchanged.
- **Busy start:** `start` while busy has no effect.

## Test plan
- **Reset:** assert `rstn`=0 mid-frame at an arbitrary cycle. Then all outputs = 0, `busy`=0, and after release the next `start` restarts at {row 0, col 0, ch 0}.
- **Small frame** (LANES=4, WORDS=2, H_IN=4, CHANNELS=2), FIFO always valid, `pool_ready`=1, pixel value = y*16+x:
  - 8 pooled words, in order row0 col0..1, row1 col0..1, per channel.
  - Row0 col0 lanes = {17, 19}.
  - `done` pulses once; total reads = 16.
- **Signed data:** row0 word {-5, -3, -128, 127}, row1 word {-4, -9, -1, -2} -> pooled {-3, 127}.
- **Backpressure:**
  - Hold `pool_ready`=0 through an odd row. At most 2 words are queued, `rden` stops, and no data is lost.
  - Release: words emerge in order with unchanged values.
- **Bursty FIFO:** toggle `pe2row_data_valid` randomly. `rden` is never asserted while valid=0, and the output matches the golden model.
- **Frame completion:** `start` during FLUSH is ignored. `done` occurs exactly once after the last pop, and `busy` falls the following cycle.

Source files
------------

// File: rtl/pe_out_pool_reader.sv
// pe_out_pool_reader
//   Reading end of the pe2row FIFO interface. Drains PE output words and
//   applies 2x2 / stride-2 signed max pooling. Even input rows are reduced
//   horizontally into a one-row line buffer. Odd input rows are reduced
//   horizontally, combined with the buffered even row, and queued for the
//   next layer's row-buffer writer.
//
// Ports
//   clk, rstn                 clock, async active-low reset
//   start                     frame start pulse (accepted in IDLE only)
//   pe2row_data_valid         FIFO non-empty
//   pe2row_fifo_array1_rden   FIFO read strobe (data returns next cycle)
//   fifo_array1_dataout       FIFO read data, LANES pixels
//   pe2row_ready              reader actively consuming rows
//   pool_data/valid/ready     pooled word handshake, LANES/2 pixels
//   pool_row/col/channel      coordinates of the pooled word
//   busy, done                frame in progress / frame complete pulse

// One output lane: horizontal max of an input pixel pair, then vertical max
// against the matching lane of the buffered even row.
module pe_pool_lane #(
  parameter int DW = 8
) (
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  input  logic signed [DW-1:0] prev,
  output logic signed [DW-1:0] hmax,
  output logic signed [DW-1:0] vmax
);
  always_comb begin
    hmax = (a > b) ? a : b;
    vmax = (hmax > prev) ? hmax : prev;
  end
endmodule

module pe_out_pool_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 8,
  parameter int WORDS      = 4,
  parameter int H_IN       = 32,
  parameter int CHANNELS   = 256,
  parameter int ROW_WIDTH  = 10
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              start,
  input  logic                              pe2row_data_valid,
  output logic                              pe2row_fifo_array1_rden,
  input  logic [LANES*DATA_WIDTH-1:0]       fifo_array1_dataout,
  output logic                              pe2row_ready,
  output logic [LANES/2*DATA_WIDTH-1:0]     pool_data,
  output logic                              pool_valid,
  input  logic                              pool_ready,
  output logic [ROW_WIDTH-1:0]              pool_row,
  output logic [ROW_WIDTH-1:0]              pool_col,
  output logic [ROW_WIDTH-1:0]              pool_channel,
  output logic                              busy,
  output logic                              done
);

  localparam int HL = LANES / 2;
  localparam int PW = HL * DATA_WIDTH;
  localparam int WW = (WORDS > 1)    ? $clog2(WORDS)    : 1;
  localparam int YW = (H_IN > 1)     ? $clog2(H_IN)     : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [WW-1:0] W_LAST = WW'(WORDS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(H_IN - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CHANNELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_EVEN, S_ODD, S_FLUSH} state_t;

  typedef struct packed {
    logic [PW-1:0]        data;
    logic [ROW_WIDTH-1:0] row;
    logic [ROW_WIDTH-1:0] col;
    logic [ROW_WIDTH-1:0] ch;
  } q_ent_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t          state_q, state_d;

  // read-side counters: position of the next word to be read
  logic [WW-1:0]   w_q, w_d;
  logic [YW-1:0]   y_q, y_d;
  logic [CW-1:0]   c_q, c_d;

  // snapshot of the read in flight; the data arrives one cycle after rden
  logic            inflight_q, inflight_d;
  logic            odd_s_q, odd_s_d;
  logic [WW-1:0]   w_s_q, w_s_d;
  logic [YW-1:0]   y_s_q, y_s_d;
  logic [CW-1:0]   c_s_q, c_s_d;

  logic [WORDS-1:0][PW-1:0] line_buf_q, line_buf_d;

  // 2-entry output queue
  q_ent_t          q_mem_q [2];
  q_ent_t          q_mem_d [2];
  logic            wp_q, wp_d;
  logic            rp_q, rp_d;
  logic [1:0]      q_cnt_q, q_cnt_d;

  logic            rden;
  logic            push;
  logic            pop;
  logic            w_last;
  logic            last_row;
  logic [2:0]      odd_room;

  logic [PW-1:0]   hmax;
  logic [PW-1:0]   vmax;
  logic [PW-1:0]   prev_row;

  // ---------------------------------------------------------------------
  // Datapath: per-lane pooling
  // ---------------------------------------------------------------------
  assign prev_row = line_buf_q[w_s_q];

  for (genvar j = 0; j < HL; j++) begin : g_lane
    pe_pool_lane #(.DW(DATA_WIDTH)) u_lane (
      .a    (fifo_array1_dataout[(2*j)*DATA_WIDTH   +: DATA_WIDTH]),
      .b    (fifo_array1_dataout[(2*j+1)*DATA_WIDTH +: DATA_WIDTH]),
      .prev (prev_row[j*DATA_WIDTH +: DATA_WIDTH]),
      .hmax (hmax[j*DATA_WIDTH +: DATA_WIDTH]),
      .vmax (vmax[j*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // ---------------------------------------------------------------------
  // Handshake helpers
  // ---------------------------------------------------------------------
  assign pool_valid = (q_cnt_q != 2'd0);
  assign pop        = pool_valid && pool_ready;
  assign push       = inflight_q && odd_s_q;
  assign w_last     = (w_q == W_LAST);
  assign last_row   = (y_q == Y_LAST) && (c_q == C_LAST);

  // Queue slots still claimable for odd-row reads: whatever is queued after
  // this cycle's pop plus the read already in flight. Keeps the 2-entry
  // queue from ever overflowing without a skid buffer.
  assign odd_room = {1'b0, q_cnt_q} - {2'b00, pop} + {2'b00, inflight_q};

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_EVEN;
      S_EVEN:  if (rden && w_last) state_d = S_ODD;
      S_ODD:   if (rden && w_last) state_d = last_row ? S_FLUSH : S_EVEN;
      S_FLUSH: if (!inflight_q && (q_cnt_q == 2'd0)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    rden         = 1'b0;
    pe2row_ready = 1'b0;
    busy         = (state_q != S_IDLE);
    done         = 1'b0;
    case (state_q)
      S_EVEN: begin
        rden         = pe2row_data_valid;
        pe2row_ready = 1'b1;
      end
      S_ODD: begin
        rden         = pe2row_data_valid && (odd_room < 3'd2);
        pe2row_ready = 1'b1;
      end
      S_FLUSH: done = !inflight_q && (q_cnt_q == 2'd0);
      default: ;
    endcase
  end

  assign pe2row_fifo_array1_rden = rden;

  // ---------------------------------------------------------------------
  // Read counters and in-flight snapshot
  // ---------------------------------------------------------------------
  always_comb begin
    w_d        = w_q;
    y_d        = y_q;
    c_d        = c_q;
    w_s_d      = w_s_q;
    y_s_d      = y_s_q;
    c_s_d      = c_s_q;
    odd_s_d    = odd_s_q;
    inflight_d = rden;
    if ((state_q == S_IDLE) && start) begin
      w_d = '0;
      y_d = '0;
      c_d = '0;
    end else if (rden) begin
      w_s_d   = w_q;
      y_s_d   = y_q;
      c_s_d   = c_q;
      odd_s_d = (state_q == S_ODD);
      if (w_last) begin
        w_d = '0;
        if (y_q == Y_LAST) begin
          y_d = '0;
          c_d = (c_q == C_LAST) ? '0 : c_q + CW'(1);
        end else begin
          y_d = y_q + YW'(1);
        end
      end else begin
        w_d = w_q + WW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_q        <= '0;
      y_q        <= '0;
      c_q        <= '0;
      w_s_q      <= '0;
      y_s_q      <= '0;
      c_s_q      <= '0;
      odd_s_q    <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      w_q        <= w_d;
      y_q        <= y_d;
      c_q        <= c_d;
      w_s_q      <= w_s_d;
      y_s_q      <= y_s_d;
      c_s_q      <= c_s_d;
      odd_s_q    <= odd_s_d;
      inflight_q <= inflight_d;
    end
  end

  // ---------------------------------------------------------------------
  // Line buffer: even-row horizontal maxima, no reset needed
  // ---------------------------------------------------------------------
  always_comb begin
    line_buf_d = line_buf_q;
    if (inflight_q && !odd_s_q) line_buf_d[w_s_q] = hmax;
  end

  always_ff @(posedge clk) begin
    line_buf_q <= line_buf_d;
  end

  // ---------------------------------------------------------------------
  // Output queue
  // ---------------------------------------------------------------------
  always_comb begin
    q_mem_d = q_mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    if (push) begin
      q_mem_d[wp_q].data = vmax;
      q_mem_d[wp_q].row  = ROW_WIDTH'(y_s_q) >> 1;
      q_mem_d[wp_q].col  = ROW_WIDTH'(w_s_q);
      q_mem_d[wp_q].ch   = ROW_WIDTH'(c_s_q);
      wp_d = ~wp_q;
    end
    if (pop) rp_d = ~rp_q;
    q_cnt_d = q_cnt_q + {1'b0, push} - {1'b0, pop};
  end

  // Storage is reset as well so the head fields read zero out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) q_mem_q[i] <= '0;
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      q_cnt_q <= 2'd0;
    end else begin
      q_mem_q <= q_mem_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      q_cnt_q <= q_cnt_d;
    end
  end

  assign pool_data    = q_mem_q[rp_q].data;
  assign pool_row     = q_mem_q[rp_q].row;
  assign pool_col     = q_mem_q[rp_q].col;
  assign pool_channel = q_mem_q[rp_q].ch;

endmodule

// File: tb/tb_pe_out_pool_reader.sv
module tb_pe_out_pool_reader;
  localparam int DW   = 8;
  localparam int L    = 4;
  localparam int WD   = 2;
  localparam int H    = 4;
  localparam int C    = 2;
  localparam int RW   = 10;
  localparam int PW   = L / 2 * DW;
  localparam int NPIX = L * WD;
  localparam int NRD  = C * H * WD;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            start = 1'b0;
  logic            valid = 1'b0;
  logic            rden;
  logic [L*DW-1:0] dataout = '0;
  logic            rdy_o;
  logic [PW-1:0]   pool_data;
  logic            pool_valid;
  logic            pool_ready = 1'b0;
  logic [RW-1:0]   pool_row, pool_col, pool_channel;
  logic            busy, done;

  always #5 clk = ~clk;

  pe_out_pool_reader #(
    .DATA_WIDTH(DW), .LANES(L), .WORDS(WD), .H_IN(H), .CHANNELS(C), .ROW_WIDTH(RW)
  ) dut (
    .clk                     (clk),
    .rstn                    (rstn),
    .start                   (start),
    .pe2row_data_valid       (valid),
    .pe2row_fifo_array1_rden (rden),
    .fifo_array1_dataout     (dataout),
    .pe2row_ready            (rdy_o),
    .pool_data               (pool_data),
    .pool_valid              (pool_valid),
    .pool_ready              (pool_ready),
    .pool_row                (pool_row),
    .pool_col                (pool_col),
    .pool_channel            (pool_channel),
    .busy                    (busy),
    .done                    (done)
  );

  typedef struct packed {
    logic [PW-1:0] data;
    logic [RW-1:0] row;
    logic [RW-1:0] col;
    logic [RW-1:0] ch;
  } exp_t;

  exp_t                 exp_q[$];
  logic [L*DW-1:0]      fifo_q[$];
  logic signed [DW-1:0] pix [C][H][NPIX];

  int   n_chk = 0, n_pass = 0;
  int   cyc = 0;
  bit   rd_pend = 0;
  int   rd_cnt = 0, pop_cnt = 0, odd_rd = 0, done_cnt = 0;
  int   first_rd_cyc = -1, first_odd_cyc = -1, first_vld_cyc = -1, last_rd_cyc = -1;
  exp_t e_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  // Monitor: FIFO read legality, scoreboard pops, queue bound, done pulses.
  always @(negedge clk) begin
    if (rstn) begin
      if (rden) begin
        chk("rden_needs_valid", valid, 1);
        if (rd_cnt == 0)  first_rd_cyc = cyc;
        if (rd_cnt == WD) first_odd_cyc = cyc;
        last_rd_cyc = cyc;
        if (((rd_cnt / WD) % H) % 2 == 1) odd_rd++;
        rd_cnt++;
        rd_pend = 1;
      end else begin
        rd_pend = 0;
      end
      if (pool_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (pool_valid && pool_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_pool_word", 1, 0);
        end else begin
          e_m = exp_q.pop_front();
          chk("pool_data", pool_data, e_m.data);
          chk("pool_row", pool_row, e_m.row);
          chk("pool_col", pool_col, e_m.col);
          chk("pool_channel", pool_channel, e_m.ch);
        end
      end
      if (rden && (((rd_cnt - 1) / WD) % H) % 2 == 1)
        chk("queue_bound", (odd_rd - pop_cnt) <= 2, 1);
      if (done) begin
        done_cnt++;
        chk("done_after_last_pop", exp_q.size(), 0);
      end
    end else begin
      rd_pend = 0;
    end
  end

  // One cycle of stimulus, applied just after the rising edge.
  task automatic drive(input bit st, input bit flush_st, input int vprob, input int rprob);
    @(posedge clk); #1;
    if (rd_pend && fifo_q.size() > 0) dataout = fifo_q.pop_front();
    else                              dataout = $urandom;
    start      = st || (flush_st && rd_cnt == NRD && done_cnt == 0);
    valid      = (fifo_q.size() > 0) && ($urandom_range(99) < vprob);
    pool_ready = ($urandom_range(99) < rprob);
  endtask

  // Reference: image in, FIFO words and pooled words out.
  task automatic build(input int mode);
    logic [L*DW-1:0] wv;
    exp_t e;
    int m, v;
    for (int c = 0; c < C; c++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < NPIX; x++)
          pix[c][y][x] = (mode == 0) ? DW'(y * 16 + x) : DW'($urandom_range(255));
    if (mode == 2) begin
      pix[0][0][0] = -5; pix[0][0][1] = -3; pix[0][0][2] = -128; pix[0][0][3] = 127;
      pix[0][1][0] = -4; pix[0][1][1] = -9; pix[0][1][2] = -1;   pix[0][1][3] = -2;
    end
    fifo_q.delete();
    exp_q.delete();
    for (int c = 0; c < C; c++)
      for (int y = 0; y < H; y++)
        for (int w = 0; w < WD; w++) begin
          for (int i = 0; i < L; i++) wv[i*DW +: DW] = pix[c][y][w*L + i];
          fifo_q.push_back(wv);
        end
    for (int c = 0; c < C; c++)
      for (int r = 0; r < H / 2; r++)
        for (int w = 0; w < WD; w++) begin
          for (int j = 0; j < L / 2; j++) begin
            m = -1000;
            for (int dy = 0; dy < 2; dy++)
              for (int dx = 0; dx < 2; dx++) begin
                v = pix[c][2*r + dy][w*L + 2*j + dx];
                if (v > m) m = v;
              end
            e.data[j*DW +: DW] = m[DW-1:0];
          end
          e.row = RW'(r);
          e.col = RW'(w);
          e.ch  = RW'(c);
          exp_q.push_back(e);
        end
  endtask

  task automatic clear_counts();
    rd_cnt = 0; pop_cnt = 0; odd_rd = 0; done_cnt = 0;
    first_rd_cyc = -1; first_odd_cyc = -1; first_vld_cyc = -1; last_rd_cyc = -1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_rden", rden, 0);
    chk("rst_pe2row_ready", rdy_o, 0);
    chk("rst_pool_valid", pool_valid, 0);
    chk("rst_pool_data", pool_data, 0);
    chk("rst_pool_row", pool_row, 0);
    chk("rst_pool_col", pool_col, 0);
    chk("rst_pool_channel", pool_channel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rstn = 1'b0; start = 1'b0; valid = 1'b0; pool_ready = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    fifo_q.delete();
    exp_q.delete();
    rd_pend = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  int start_cyc;

  task automatic run_frame(input int mode, input int vprob, input int rprob,
                           input int hold, input bit flush_st);
    int n;
    build(mode);
    clear_counts();
    drive(1'b1, 1'b0, vprob, (hold > 0) ? 0 : rprob);
    start_cyc = cyc;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      if (hold > 0 && n == hold) begin
        chk("bp_reads_stalled", rd_cnt, 3 * WD);
        chk("bp_queue_full_valid", pool_valid, 1);
      end
      drive(1'b0, flush_st, vprob, (n < hold) ? 0 : rprob);
      n++;
    end
    chk("frame_done_seen", done_cnt > 0, 1);
    if (done_cnt == 0) begin
      pulse_reset();
    end else begin
      @(negedge clk);
      chk("busy_falls_after_done", busy, 0);
      repeat (3) drive(1'b0, 1'b0, vprob, rprob);
      @(negedge clk);
      chk("idle_stays_idle", busy, 0);
      chk("done_once", done_cnt, 1);
      chk("total_reads", rd_cnt, NRD);
      chk("all_words_out", exp_q.size(), 0);
      chk("fifo_drained", fifo_q.size(), 0);
    end
  endtask

  initial begin
    // reset values
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1 rstn = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 100, 100);

    // ramp frame, free-flowing: order, values, first-read/latency/throughput
    run_frame(0, 100, 100, 0, 1'b0);
    chk("first_rd_after_start", first_rd_cyc, start_cyc + 1);
    chk("odd_latency", first_vld_cyc - first_odd_cyc, 2);
    chk("full_throughput", last_rd_cyc - first_rd_cyc, NRD - 1);

    // signed corner values
    run_frame(2, 100, 100, 0, 1'b0);

    // output held off across an odd row, then released
    run_frame(1, 100, 60, 40, 1'b0);

    // start pulses while flushing are ignored
    run_frame(1, 100, 40, 0, 1'b1);

    // reset in the middle of a frame, then a clean restart
    build(1);
    clear_counts();
    drive(1'b1, 1'b0, 70, 50);
    repeat ($urandom_range(12, 3)) drive(1'b0, 1'b0, 70, 50);
    pulse_reset();
    repeat (2) drive(1'b0, 1'b0, 100, 100);
    run_frame(1, 60, 60, 0, 1'b0);

    // bursty FIFO / random backpressure
    for (int k = 0; k < 6; k++)
      run_frame(1, $urandom_range(100, 30), $urandom_range(100, 30), 0, k[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
